// File: rtl/mcc_add_sequencer.sv
// Round-robin two-port front end that walks WIDTH-bit adds through a shared
// SLICE-bit dynamic Manchester-carry-chain block, one precharge/evaluate pair per chunk.
module mcc_add_sequencer #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic [SLICE-1:0] add_a,
    output logic [SLICE-1:0] add_b,
    output logic             add_cin,
    output logic             add_eval,
    input  logic [SLICE-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy
);

    localparam int NCH = WIDTH / SLICE;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    chunk, chunk_nxt;
    logic             rr_ptr, carry, id_q;
    logic [WIDTH-1:0] op_a, op_b, result;
    logic             grant0, grant1, accept, last_chunk;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_cin;

    function automatic logic [SLICE-1:0] chunk_of(input logic [WIDTH-1:0] v,
                                                  input logic [CW-1:0]    c);
        return v[int'(c)*SLICE +: SLICE];
    endfunction

    // Tie goes to the requester that was not served last.
    assign grant0     = req0_valid & (~req1_valid | rr_ptr);
    assign grant1     = req1_valid & (~req0_valid | ~rr_ptr);
    assign accept     = (state == S_IDLE) & (grant0 | grant1);
    assign last_chunk = (int'(chunk) == NCH - 1);
    assign chunk_nxt  = chunk + 1'b1;

    always_comb begin
        sel_a   = grant0 ? req0_a   : req1_a;
        sel_b   = grant0 ? req0_b   : req1_b;
        sel_cin = grant0 ? req0_cin : req1_cin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        add_eval   = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy       = 1'b0;
                req0_ready = grant0;
                req1_ready = grant1;
                if (accept) state_nxt = S_PRE;
            end
            S_PRE: state_nxt = S_EVAL;
            S_EVAL: begin
                add_eval  = 1'b1;
                state_nxt = last_chunk ? S_DONE : S_PRE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Slice operands are registered so they only move on entry to PRE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= 1'b1;
            chunk   <= '0;
            carry   <= 1'b0;
            id_q    <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        carry   <= sel_cin;
                        id_q    <= grant1;
                        rr_ptr  <= grant1;
                        chunk   <= '0;
                        add_a   <= sel_a[SLICE-1:0];
                        add_b   <= sel_b[SLICE-1:0];
                        add_cin <= sel_cin;
                    end
                end
                S_EVAL: begin
                    result[int'(chunk)*SLICE +: SLICE] <= add_sum;
                    carry <= add_cout;
                    if (!last_chunk) begin
                        chunk   <= chunk_nxt;
                        add_a   <= chunk_of(op_a, chunk_nxt);
                        add_b   <= chunk_of(op_b, chunk_nxt);
                        add_cin <= add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_sum  = result;
    assign rsp_cout = carry;
    assign rsp_id   = id_q;

endmodule

// File: tb/tb_mcc_add_sequencer.sv
// Directed bench for mcc_add_sequencer: vector table, arbitration, backpressure,
// mid-operation reset and a randomized scoreboard run, with a behavioural slice adder.
module tb_mcc_add_sequencer;

    localparam int WIDTH = 64;
    localparam int SLICE = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_cin;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic [SLICE-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_eval, add_cout, busy;
    logic [SLICE:0]   slice_res;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic        id;
        logic [64:0] res;
    } rec_t;

    mcc_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_eval(add_eval),
        .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slice output is garbage while precharging, so early sampling shows up.
    always_comb begin
        slice_res = '1;
        if (add_eval) slice_res = {1'b0, add_a} + {1'b0, add_b} + {{SLICE{1'b0}}, add_cin};
    end
    assign add_sum  = slice_res[SLICE-1:0];
    assign add_cout = slice_res[SLICE];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic cin);
        logic ok = 1'b0;
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", ok, 1);
        @(posedge clk);
        @(negedge clk);
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    // Entered at the negedge right after the accepting edge.
    task automatic wait_rsp(input string name, input logic id, input logic [63:0] sum,
                            input logic cout);
        logic [7:0] pat = '0;
        int lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (k < 8) pat[k] = add_eval;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({name, "_lat"}, lat, 8);
        check({name, "_eval"}, pat, 8'b1010_1010);
        check({name, "_sum"}, {rsp_cout, rsp_sum}, {cout, sum});
        check({name, "_id"}, rsp_id, id);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[7];
    rec_t exp_q[$];

    initial begin
        logic        exp_id[4];
        logic [63:0] exp_sum[4];
        int n, seen, accepted, cyc;
        logic drop0, drop1;
        rec_t r;

        vecs[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[2] = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[3] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1};
        vecs[4] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1};
        vecs[5] = '{1'b1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0};
        vecs[6] = '{1'b0, 64'h0, 64'h0, 1'b1, 64'h1, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b1;

        #3;
        check("reset_outputs", {rsp_valid, busy, add_eval, add_a, add_b, add_cin, rsp_sum,
                                rsp_cout, rsp_id, req0_ready, req1_ready}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters contend from reset: req0 wins first, then strict alternation.
        exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_sum = '{64'd12, 64'd102, 64'd12, 64'd102};
        req0_a = 64'd5;   req0_b = 64'd7; req0_cin = 1'b0; req0_valid = 1'b1;
        req1_a = 64'd100; req1_b = 64'd1; req1_cin = 1'b1; req1_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            if (rsp_valid) begin
                check($sformatf("tie%0d_id", n), rsp_id, exp_id[n]);
                check($sformatf("tie%0d_sum", n), {rsp_cout, rsp_sum}, {1'b0, exp_sum[n]});
                n++;
                if (n == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("tie_count", n, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < $size(vecs); i++) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_rsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].sum, vecs[i].cout);
            finish_rsp();
        end

        // Response stall with both requesters waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 64'd3, 64'd4, 1'b0);
        req1_a = 64'd10;    req1_b = 64'd20;    req1_cin = 1'b0; req1_valid = 1'b1;
        req0_a = 64'h100;   req0_b = 64'h200;   req0_cin = 1'b1; req0_valid = 1'b1;
        wait_rsp("bp", 1'b0, 64'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i),
                  {rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_cout, rsp_sum},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd7});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_resume", {rsp_valid, busy, req0_ready, req1_ready}, 4'b0001);
        issue(1'b1, 64'd10, 64'd20, 1'b0);
        wait_rsp("bp_r1", 1'b1, 64'd30, 1'b0);
        finish_rsp();
        issue(1'b0, 64'h100, 64'h200, 1'b1);
        wait_rsp("bp_r0", 1'b0, 64'h301, 1'b0);
        finish_rsp();

        // Reset during the third chunk's evaluate phase.
        issue(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_eval", add_eval, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset", {rsp_valid, busy, add_eval, add_a, add_b, add_cin, rsp_sum,
                            rsp_cout, rsp_id, req0_ready, req1_ready}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        check("mid_quiet", seen, 0);
        issue(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        wait_rsp("post_reset", 1'b0, 64'h0, 1'b1);
        finish_rsp();

        // Randomized traffic against an in-order scoreboard.
        accepted = 0;
        cyc = 0;
        drop0 = 1'b0;
        drop1 = 1'b0;
        while ((accepted < 1000 || exp_q.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (drop0) req0_valid = 1'b0;
            if (drop1) req1_valid = 1'b0;
            drop0 = 1'b0;
            drop1 = 1'b0;
            if (!req0_valid && accepted < 1000 && $urandom_range(0, 3) != 0) begin
                req0_a   = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
                req0_b   = {$urandom, $urandom};
                req0_cin = 1'($urandom_range(0, 1));
                req0_valid = 1'b1;
            end
            if (!req1_valid && accepted < 1000 && $urandom_range(0, 3) != 0) begin
                req1_a   = {$urandom, $urandom};
                req1_b   = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
                req1_cin = 1'($urandom_range(0, 1));
                req1_valid = 1'b1;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", rsp_valid, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("rand_id", rsp_id, r.id);
                    check("rand_sum", {rsp_cout, rsp_sum}, r.res);
                end
            end
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{1'b0, {1'b0, req0_a} + {1'b0, req0_b} + 65'(req0_cin)});
                accepted++;
                drop0 = 1'b1;
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{1'b1, {1'b0, req1_a} + {1'b0, req1_b} + 65'(req1_cin)});
                accepted++;
                drop1 = 1'b1;
            end
        end
        check("rand_drain", exp_q.size(), 0);
        check("rand_accepted", accepted >= 1000, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
